// File: rtl/gray_frame_reader.sv
// Read-side pixel buffer between the SDRAM read port and the VGA controller.
// Buffers 12-bit grayscale pixels in a small FIFO and serves them as 10-bit R=G=B on request.
module gray_frame_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int PREFILL    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        frame_start,
  input  logic        pix_req,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic        pix_valid,
  output logic        underflow,
  output logic        frame_done,
  output logic [9:0]  x_cnt,
  output logic [8:0]  y_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PREFILL_C = CW'(PREFILL);
  localparam logic [9:0]    X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [8:0]    Y_LAST    = 9'(V_ACTIVE - 1);

  typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_STREAM} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [9:0]      rgb_q, rgb_d;
  logic            pix_valid_q, pix_valid_d;
  logic            underflow_q, underflow_d;
  logic            frame_done_q, frame_done_d;
  logic [9:0]      x_q, x_d;
  logic [8:0]      y_q, y_d;

  // Only the upper 10 bits of each pixel are ever displayed, so only those are stored.
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic            unused_lsbs;
  logic            ready_c, push, pop, serve;

  assign unused_lsbs = ^in_data[1:0];

  always_comb begin
    ready_c = (state_q != S_IDLE) && (count_q < DEPTH_C);
    push    = in_valid && ready_c && !frame_start;
    serve   = (state_q == S_STREAM) && pix_req && !frame_start;
    pop     = serve && (count_q != '0);

    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rgb_d        = rgb_q;
    pix_valid_d  = 1'b0;
    underflow_d  = underflow_q;
    frame_done_d = 1'b0;
    x_d          = x_q;
    y_d          = y_q;

    if (frame_start) begin
      state_d  = S_PREFILL;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      x_d      = '0;
      y_d      = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);

      case (state_q)
        S_PREFILL: begin
          if (count_q >= PREFILL_C) state_d = S_STREAM;
        end
        S_STREAM: begin
          if (serve) begin
            pix_valid_d = 1'b1;
            // An empty FIFO still consumes the request: black is shown and the position advances.
            rgb_d = pop ? mem_q[rd_ptr_q] : '0;
            if (!pop) underflow_d = 1'b1;
            if (x_q == X_LAST) begin
              x_d = '0;
              if (y_q == Y_LAST) begin
                y_d          = '0;
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
              end else begin
                y_d = y_q + 1'b1;
              end
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data[11:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rgb_q        <= '0;
      pix_valid_q  <= 1'b0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rgb_q        <= rgb_d;
      pix_valid_q  <= pix_valid_d;
      underflow_q  <= underflow_d;
      frame_done_q <= frame_done_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  assign in_ready   = ready_c;
  assign oRed       = rgb_q;
  assign oGreen     = rgb_q;
  assign oBlue      = rgb_q;
  assign pix_valid  = pix_valid_q;
  assign underflow  = underflow_q;
  assign frame_done = frame_done_q;
  assign x_cnt      = x_q;
  assign y_cnt      = y_q;

endmodule
